// File: rtl/tl45_register_read_fwd.sv
// Register-read stage: DPRF read, prioritised operand forwarding, load scoreboard, load-use bubbles.
// Optional: define TL45_RR_PERF_CNT_EN to add the o_bubble_cnt hazard-bubble counter.
module tl45_register_read_fwd #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 16,
  parameter  int NUM_FWD  = 2,
  parameter  int OPC_W    = 5,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_pipe_stall,
  input  logic                      i_pipe_flush,
  output logic                      o_pipe_stall,
  output logic                      o_pipe_flush,
  input  logic [OPC_W-1:0]          i_opcode,
  input  logic                      i_ri,
  input  logic                      i_is_load,
  input  logic [REG_AW-1:0]         i_dr,
  input  logic [REG_AW-1:0]         i_sr1,
  input  logic [REG_AW-1:0]         i_sr2,
  input  logic [XLEN-1:0]           i_imm32,
  input  logic [XLEN-1:0]           i_pc,
  output logic [REG_AW-1:0]         o_dprf_read_a1,
  output logic [REG_AW-1:0]         o_dprf_read_a2,
  input  logic [XLEN-1:0]           i_dprf_d1,
  input  logic [XLEN-1:0]           i_dprf_d2,
  input  logic [NUM_FWD-1:0]        i_of_valid,
  input  logic [NUM_FWD*REG_AW-1:0] i_of_reg,
  input  logic [NUM_FWD*XLEN-1:0]   i_of_data,
  input  logic                      i_ld_wb_valid,
  input  logic [REG_AW-1:0]         i_ld_wb_reg,
  output logic [OPC_W-1:0]          o_opcode,
  output logic [REG_AW-1:0]         o_dr,
  output logic                      o_is_load,
  output logic [XLEN-1:0]           o_sr1_val,
  output logic [XLEN-1:0]           o_sr2_val,
  output logic [XLEN-1:0]           o_target_address_offset,
`ifdef TL45_RR_PERF_CNT_EN
  output logic [31:0]               o_bubble_cnt,
`endif
  output logic [XLEN-1:0]           o_pc
);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] dr;
    logic              is_load;
    logic [XLEN-1:0]   sr1_val;
    logic [XLEN-1:0]   sr2_val;
    logic [XLEN-1:0]   offset;
    logic [XLEN-1:0]   pc;
  } rr_buf_t;

  rr_buf_t               buf_q, buf_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [NUM_REGS-1:0]   wb_clr;
  logic                  sr1_hit, sr2_hit;
  logic [XLEN-1:0]       sr1_fwd, sr2_fwd;
  logic [XLEN-1:0]       sr1_val, sr2_val;
  logic                  sr1_busy, sr2_busy, hazard;

  assign o_dprf_read_a1 = i_sr1;
  assign o_dprf_read_a2 = i_sr2;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  // Descending scan: the lowest-index (youngest) matching bus is assigned last and wins.
  always_comb begin
    sr1_hit = 1'b0;
    sr2_hit = 1'b0;
    sr1_fwd = '0;
    sr2_fwd = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_of_valid[k] && i_of_reg[k*REG_AW +: REG_AW] == i_sr1) begin
        sr1_hit = 1'b1;
        sr1_fwd = i_of_data[k*XLEN +: XLEN];
      end
      if (i_of_valid[k] && i_of_reg[k*REG_AW +: REG_AW] == i_sr2) begin
        sr2_hit = 1'b1;
        sr2_fwd = i_of_data[k*XLEN +: XLEN];
      end
    end
  end

  assign sr1_val = (i_sr1 == '0) ? '0 : (sr1_hit ? sr1_fwd : i_dprf_d1);
  assign sr2_val = i_ri ? i_imm32 : ((i_sr2 == '0) ? '0 : (sr2_hit ? sr2_fwd : i_dprf_d2));

  // A write-back in this cycle already satisfies the consumer through the DPRF.
  assign wb_clr = i_ld_wb_valid ? (NUM_REGS'(1) << i_ld_wb_reg) : '0;

  assign sr1_busy = (i_sr1 != '0) && pending_q[i_sr1] && !wb_clr[i_sr1] && !sr1_hit;
  assign sr2_busy = (i_sr2 != '0) && pending_q[i_sr2] && !wb_clr[i_sr2] && !sr2_hit;
  assign hazard   = !i_reset && !i_pipe_flush && (i_opcode != '0) &&
                    (sr1_busy || (!i_ri && sr2_busy));

  assign o_pipe_stall = i_pipe_stall | hazard;
  assign o_pipe_flush = i_pipe_flush;

  always_comb begin
    buf_d     = buf_q;
    pending_d = pending_q & ~wb_clr;
    if (i_pipe_flush) begin
      buf_d = '0;
      if (buf_q.is_load) pending_d[buf_q.dr] = 1'b0;
    end else if (i_pipe_stall) begin
      buf_d = buf_q;
    end else if (hazard) begin
      buf_d.opcode  = '0;
      buf_d.dr      = '0;
      buf_d.is_load = 1'b0;
      buf_d.sr1_val = '0;
      buf_d.sr2_val = '0;
    end else begin
      buf_d.opcode  = i_opcode;
      buf_d.dr      = i_dr;
      buf_d.is_load = i_is_load;
      buf_d.sr1_val = sr1_val;
      buf_d.sr2_val = sr2_val;
      buf_d.offset  = i_imm32;
      buf_d.pc      = i_pc;
      // Applied after the write-back clear so a same-cycle set wins.
      if (i_is_load && i_dr != '0) pending_d[i_dr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a handful of flops, not a memory, so it is reset with the buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_q     <= '0;
      pending_q <= '0;
    end else begin
      buf_q     <= buf_d;
      pending_q <= pending_d;
    end
  end

`ifdef TL45_RR_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  assign bubble_cnt_d = bubble_cnt_q + 32'((!i_pipe_stall && hazard) ? 1 : 0);

  always_ff @(posedge i_clk) begin
    if (i_reset) bubble_cnt_q <= '0;
    else         bubble_cnt_q <= bubble_cnt_d;
  end

  assign o_bubble_cnt = bubble_cnt_q;
`endif

  assign o_opcode                = buf_q.opcode;
  assign o_dr                    = buf_q.dr;
  assign o_is_load               = buf_q.is_load;
  assign o_sr1_val               = buf_q.sr1_val;
  assign o_sr2_val               = buf_q.sr2_val;
  assign o_target_address_offset = buf_q.offset;
  assign o_pc                    = buf_q.pc;

endmodule

// File: tb/tb_tl45_register_read_fwd.sv
// Randomised bench for tl45_register_read_fwd against a cycle-level reference model of the stage.
module tb_tl45_register_read_fwd;
  localparam int XLEN = 32;
  localparam int NR   = 16;
  localparam int NF   = 2;
  localparam int OW   = 5;
  localparam int AW   = 4;

  logic            i_clk = 1'b0;
  logic            i_reset, i_pipe_stall, i_pipe_flush, o_pipe_stall, o_pipe_flush;
  logic [OW-1:0]   i_opcode, o_opcode;
  logic            i_ri, i_is_load, o_is_load;
  logic [AW-1:0]   i_dr, i_sr1, i_sr2, o_dprf_read_a1, o_dprf_read_a2, o_dr, i_ld_wb_reg;
  logic [XLEN-1:0] i_imm32, i_pc, i_dprf_d1, i_dprf_d2;
  logic [NF-1:0]   i_of_valid;
  logic [NF*AW-1:0]   i_of_reg;
  logic [NF*XLEN-1:0] i_of_data;
  logic            i_ld_wb_valid;
  logic [XLEN-1:0] o_sr1_val, o_sr2_val, o_target_address_offset, o_pc;
`ifdef TL45_RR_PERF_CNT_EN
  logic [31:0]     o_bubble_cnt;
`endif

  tl45_register_read_fwd #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_FWD(NF), .OPC_W(OW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush), .i_opcode(i_opcode), .i_ri(i_ri),
    .i_is_load(i_is_load), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2), .i_imm32(i_imm32),
    .i_pc(i_pc), .o_dprf_read_a1(o_dprf_read_a1), .o_dprf_read_a2(o_dprf_read_a2),
    .i_dprf_d1(i_dprf_d1), .i_dprf_d2(i_dprf_d2), .i_of_valid(i_of_valid), .i_of_reg(i_of_reg),
    .i_of_data(i_of_data), .i_ld_wb_valid(i_ld_wb_valid), .i_ld_wb_reg(i_ld_wb_reg),
    .o_opcode(o_opcode), .o_dr(o_dr), .o_is_load(o_is_load), .o_sr1_val(o_sr1_val),
    .o_sr2_val(o_sr2_val), .o_target_address_offset(o_target_address_offset),
`ifdef TL45_RR_PERF_CNT_EN
    .o_bubble_cnt(o_bubble_cnt),
`endif
    .o_pc(o_pc)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: scoreboard as a plain array of flags plus the expected buffer contents.
  bit              m_pend [NR];
  logic [OW-1:0]   m_op;
  logic [AW-1:0]   m_dr;
  logic            m_ld;
  logic [XLEN-1:0] m_s1, m_s2, m_off, m_pc;
  int unsigned     m_bub;

  function automatic bit bus_supplies(input logic [AW-1:0] r);
    for (int k = 0; k < NF; k++)
      if (i_of_valid[k] && i_of_reg[k*AW +: AW] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [AW-1:0] r, input logic [XLEN-1:0] dprf);
    if (r == 0) return '0;
    for (int k = 0; k < NF; k++)
      if (i_of_valid[k] && i_of_reg[k*AW +: AW] == r) return i_of_data[k*XLEN +: XLEN];
    return dprf;
  endfunction

  function automatic bit waiting_on(input logic [AW-1:0] r);
    if (r == 0 || !m_pend[r]) return 1'b0;
    if (i_ld_wb_valid && i_ld_wb_reg == r) return 1'b0;
    return !bus_supplies(r);
  endfunction

  function automatic bit model_hazard();
    if (i_reset || i_pipe_flush || i_opcode == 0) return 1'b0;
    return waiting_on(i_sr1) || (!i_ri && waiting_on(i_sr2));
  endfunction

  task automatic idle_inputs();
    i_reset = 0; i_pipe_stall = 0; i_pipe_flush = 0; i_opcode = 0; i_ri = 0; i_is_load = 0;
    i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_imm32 = 0; i_pc = 0; i_dprf_d1 = 0; i_dprf_d2 = 0;
    i_of_valid = 0; i_of_reg = 0; i_of_data = 0; i_ld_wb_valid = 0; i_ld_wb_reg = 0;
  endtask

  // One clock: check combinational outputs, advance the model, check the buffer after the edge.
  task automatic step();
    bit hz;
    logic [XLEN-1:0] v1, v2;
    #1;
    hz = model_hazard();
    v1 = operand(i_sr1, i_dprf_d1);
    v2 = i_ri ? i_imm32 : operand(i_sr2, i_dprf_d2);
    check("pipe_stall", o_pipe_stall, i_pipe_stall | hz);
    check("pipe_flush", o_pipe_flush, i_pipe_flush);
    check("read_a1", o_dprf_read_a1, i_sr1);
    check("read_a2", o_dprf_read_a2, i_sr2);
    if (i_reset) begin
      foreach (m_pend[r]) m_pend[r] = 0;
      m_op = 0; m_dr = 0; m_ld = 0; m_s1 = 0; m_s2 = 0; m_off = 0; m_pc = 0; m_bub = 0;
    end else begin
      if (i_ld_wb_valid) m_pend[i_ld_wb_reg] = 0;
      if (i_pipe_flush) begin
        if (m_ld) m_pend[m_dr] = 0;
        m_op = 0; m_dr = 0; m_ld = 0; m_s1 = 0; m_s2 = 0; m_off = 0; m_pc = 0;
      end else if (!i_pipe_stall) begin
        if (hz) begin
          m_op = 0; m_dr = 0; m_ld = 0; m_s1 = 0; m_s2 = 0;
          m_bub++;
        end else begin
          m_op = i_opcode; m_dr = i_dr; m_ld = i_is_load; m_s1 = v1; m_s2 = v2;
          m_off = i_imm32; m_pc = i_pc;
          if (i_is_load && i_dr != 0) m_pend[i_dr] = 1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    check("opcode", o_opcode, m_op);
    check("dr", o_dr, m_dr);
    check("is_load", o_is_load, m_ld);
    check("sr1_val", o_sr1_val, m_s1);
    check("sr2_val", o_sr2_val, m_s2);
    check("offset", o_target_address_offset, m_off);
    check("pc", o_pc, m_pc);
`ifdef TL45_RR_PERF_CNT_EN
    check("bubble_cnt", o_bubble_cnt, m_bub);
`endif
  endtask

  initial begin
    idle_inputs();
    @(negedge i_clk);
    i_reset = 1; step();
    i_reset = 1; step();
    idle_inputs();

    // r0 is never forwarded
    i_opcode = 1; i_sr1 = 0; i_of_valid = 2'b01; i_of_reg = 0; i_of_data = {32'h0, 32'hDEAD};
    i_pc = 32'h100; i_imm32 = 32'h4;
    step();
    check("r0_fwd", o_sr1_val, 0);

    // youngest bus wins over older bus and DPRF
    idle_inputs();
    i_opcode = 1; i_sr1 = 3; i_sr2 = 3; i_of_valid = 2'b11;
    i_of_reg = {4'd3, 4'd3}; i_of_data = {32'h22, 32'h11}; i_dprf_d1 = 32'h33; i_dprf_d2 = 32'h33;
    step();
    check("prio_sr1", o_sr1_val, 32'h11);
    check("prio_sr2", o_sr2_val, 32'h11);

    // load-use bubble released by write-back
    idle_inputs();
    i_opcode = 2; i_is_load = 1; i_dr = 5; step();
    idle_inputs();
    i_opcode = 3; i_sr1 = 5; i_dprf_d1 = 32'h55;
    #1 check("lu_stall", o_pipe_stall, 1);
    step();
    check("lu_nop", o_opcode, 0);
    i_ld_wb_valid = 1; i_ld_wb_reg = 5;
    #1 check("lu_release", o_pipe_stall, 0);
    step();
    check("lu_opcode", o_opcode, 3);
    check("lu_value", o_sr1_val, 32'h55);

    // set beats clear on the same register
    idle_inputs();
    i_opcode = 2; i_is_load = 1; i_dr = 7; i_ld_wb_valid = 1; i_ld_wb_reg = 7; step();
    idle_inputs();
    i_opcode = 3; i_sr2 = 7;
    #1 check("race_stall", o_pipe_stall, 1);
    step();
    i_ld_wb_valid = 1; i_ld_wb_reg = 7; step();

    // flush kills the buffered load and its scoreboard entry
    idle_inputs();
    i_opcode = 2; i_is_load = 1; i_dr = 4; step();
    idle_inputs();
    i_pipe_flush = 1; step();
    check("flush_op", o_opcode, 0);
    idle_inputs();
    i_opcode = 3; i_sr1 = 4;
    #1 check("flush_nostall", o_pipe_stall, 0);
    step();

    // three bubbles, then reset clears the counter
    idle_inputs();
    i_reset = 1; step();
    idle_inputs();
    i_opcode = 2; i_is_load = 1; i_dr = 6; step();
    idle_inputs();
    i_opcode = 3; i_sr1 = 6;
    repeat (3) step();
`ifdef TL45_RR_PERF_CNT_EN
    check("perf_three", o_bubble_cnt, 3);
`endif
    idle_inputs();
    i_reset = 1; step();
`ifdef TL45_RR_PERF_CNT_EN
    check("perf_reset", o_bubble_cnt, 0);
`endif

    // randomised traffic over a small register window so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      i_reset      = ($urandom_range(0, 199) == 0);
      i_pipe_stall = ($urandom_range(0, 9) == 0);
      i_pipe_flush = ($urandom_range(0, 29) == 0);
      i_opcode     = OW'($urandom_range(0, 4));
      i_ri         = ($urandom_range(0, 9) < 3);
      i_is_load    = ($urandom_range(0, 9) < 4);
      i_dr         = AW'($urandom_range(0, 6));
      i_sr1        = AW'($urandom_range(0, 6));
      i_sr2        = AW'($urandom_range(0, 6));
      i_imm32      = $urandom;
      i_pc         = $urandom;
      i_dprf_d1    = $urandom;
      i_dprf_d2    = $urandom;
      for (int k = 0; k < NF; k++) begin
        i_of_valid[k]          = ($urandom_range(0, 3) == 0);
        i_of_reg[k*AW +: AW]   = AW'($urandom_range(0, 6));
        i_of_data[k*XLEN +: XLEN] = $urandom;
      end
      i_ld_wb_valid = ($urandom_range(0, 9) < 3);
      i_ld_wb_reg   = AW'($urandom_range(0, 6));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
